// File: rtl/reset_sequencer_pkg.sv
// Shared types and constants for the staged board reset sequencer.
// Latency: n/a (package). Backpressure: n/a.
// Contents: FSM state encoding, synchronizer depths, constant max helper.
package reset_sequencer_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        HOLD      = 2'd1,
        RELEASE   = 2'd2,
        DONE      = 2'd3
    } rst_seq_state_t;

    localparam int RST_SYNC_STAGES  = 3;
    localparam int LOCK_SYNC_STAGES = 2;

    // Elaboration-time helper used to size the shared counters.
    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/reset_sequencer_timer.sv
// Loadable saturating down-counter with a zero flag, shared by filter/hold/step timing.
// Latency: load takes effect on the next edge; done reflects the registered count.
// Backpressure: none; en only decrements, counting stops at zero.
// Ports: clk, rst (async, active-high), load/load_val, en (decrement), done (count == 0).
module reset_sequencer_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         done
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign done = (cnt_q == '0);

endmodule

// File: rtl/rst_sync.sv
// Async-assert / sync-deassert reset synchronizer (active-high in and out).
// Latency: assertion immediate; deassertion on the STAGES-th clk edge after async_reset falls.
// Backpressure: none.
// Ports: clk, async_reset (raw async reset), sync_reset (synchronized reset).
module rst_sync #(
    parameter int STAGES = 3
) (
    input  logic clk,
    input  logic async_reset,
    output logic sync_reset
);

    (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or posedge async_reset) begin
        if (async_reset) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], 1'b0};
        end
    end

    assign sync_reset = sync_q[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Staged board reset controller: filters PLL lock, holds, then releases domain resets in index order.
// Latency: domain_reset[0] falls 2+LOCK_FILTER+HOLD_CYCLES edges after lock; STEP_CYCLES per further domain.
// Backpressure: none; lock loss restarts from WAIT_LOCK, sw_reset_req (RELEASE/DONE) restarts from HOLD.
// Ports: clk, async_reset (async active-high), pll_locked (async), sw_reset_req (clk-sync pulse),
//        domain_reset[NUM_DOMAINS], seq_done, lock_timeout, state_dbg.
// Optional: RST_SEQ_WATCHDOG_EN builds the lock watchdog; otherwise lock_timeout is tied low.
module reset_sequencer
    import reset_sequencer_pkg::*;
#(
    parameter int NUM_DOMAINS = 4,
    parameter int LOCK_FILTER = 8,
    parameter int HOLD_CYCLES = 64,
    parameter int STEP_CYCLES = 16,
    parameter int WDOG_CYCLES = 65536
) (
    input  logic                   clk,
    input  logic                   async_reset,
    input  logic                   pll_locked,
    input  logic                   sw_reset_req,
    output logic [NUM_DOMAINS-1:0] domain_reset,
    output logic                   seq_done,
    output logic                   lock_timeout,
    output logic [1:0]             state_dbg
);

    localparam int CNT_MAX = max4(LOCK_FILTER, HOLD_CYCLES, STEP_CYCLES, WDOG_CYCLES);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int IDX_W   = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

    // The timer counts down and flags zero, so hold/step load one less than
    // their cycle count: the FSM acts on the edge after the count hits zero.
    // The filter loads the full count because it only decrements on lock_s=1.
    localparam logic [CNT_W-1:0] LF_LOAD   = CNT_W'(LOCK_FILTER);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] STEP_LOAD = CNT_W'(STEP_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_DOMAINS - 1);

    logic rst_i;
    logic lock_s;

    rst_seq_state_t         state_q, state_d;
    logic [NUM_DOMAINS-1:0] dr_q, dr_d;
    logic                   done_q, done_d;
    logic [IDX_W-1:0]       idx_q, idx_d;

    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic             tmr_en;
    logic             tmr_done;

    logic             rel_go;
    logic [IDX_W-1:0] rel_idx;

    rst_sync #(
        .STAGES (RST_SYNC_STAGES)
    ) u_rst_sync (
        .clk         (clk),
        .async_reset (async_reset),
        .sync_reset  (rst_i)
    );

    // Lock synchronizer is held clear in reset so a lock already present
    // during reset still has to pass the full filter afterwards.
    (* ASYNC_REG = "TRUE" *) logic [LOCK_SYNC_STAGES-1:0] lock_sync_q;

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            lock_sync_q <= '0;
        end else begin
            lock_sync_q <= {lock_sync_q[LOCK_SYNC_STAGES-2:0], pll_locked};
        end
    end

    assign lock_s = lock_sync_q[LOCK_SYNC_STAGES-1];

    reset_sequencer_timer #(
        .W (CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst_i),
        .load     (tmr_load),
        .load_val (tmr_val),
        .en       (tmr_en),
        .done     (tmr_done)
    );

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            state_q <= WAIT_LOCK;
            dr_q    <= '1;
            done_q  <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            dr_q    <= dr_d;
            done_q  <= done_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        dr_d     = dr_q;
        done_d   = done_q;
        idx_d    = idx_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        tmr_en   = 1'b0;
        rel_go   = 1'b0;
        rel_idx  = '0;

        case (state_q)
            WAIT_LOCK: begin
                if (!lock_s) begin
                    tmr_load = 1'b1;
                    tmr_val  = LF_LOAD;
                end else if (tmr_done) begin
                    state_d  = HOLD;
                    tmr_load = 1'b1;
                    tmr_val  = HOLD_LOAD;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            HOLD: begin
                if (!lock_s) begin
                    state_d  = WAIT_LOCK;
                    dr_d     = '1;
                    done_d   = 1'b0;
                    idx_d    = '0;
                    tmr_load = 1'b1;
                    tmr_val  = LF_LOAD;
                end else if (tmr_done) begin
                    rel_go  = 1'b1;
                    rel_idx = '0;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            RELEASE, DONE: begin
                // Lock loss is checked first so it wins over a same-cycle sw request.
                if (!lock_s) begin
                    state_d  = WAIT_LOCK;
                    dr_d     = '1;
                    done_d   = 1'b0;
                    idx_d    = '0;
                    tmr_load = 1'b1;
                    tmr_val  = LF_LOAD;
                end else if (sw_reset_req) begin
                    state_d  = HOLD;
                    dr_d     = '1;
                    done_d   = 1'b0;
                    idx_d    = '0;
                    tmr_load = 1'b1;
                    tmr_val  = HOLD_LOAD;
                end else if ((state_q == RELEASE) && tmr_done) begin
                    rel_go  = 1'b1;
                    rel_idx = idx_q + 1'b1;
                end else if (state_q == RELEASE) begin
                    tmr_en = 1'b1;
                end
            end
            default: begin
                state_d = WAIT_LOCK;
                dr_d    = '1;
                done_d  = 1'b0;
                idx_d   = '0;
            end
        endcase

        // Releasing the last domain goes straight to DONE, so a single-domain
        // build skips RELEASE entirely.
        if (rel_go) begin
            dr_d[rel_idx] = 1'b0;
            idx_d         = rel_idx;
            if (rel_idx == LAST_IDX) begin
                state_d = DONE;
                done_d  = 1'b1;
            end else begin
                state_d  = RELEASE;
                tmr_load = 1'b1;
                tmr_val  = STEP_LOAD;
            end
        end
    end

`ifdef RST_SEQ_WATCHDOG_EN
    logic [CNT_W-1:0] wdog_q;
    logic             lock_timeout_q;

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            wdog_q         <= '0;
            lock_timeout_q <= 1'b0;
        end else if (state_q == WAIT_LOCK) begin
            if (wdog_q != '1) begin
                wdog_q <= wdog_q + 1'b1;
            end
            // Flag rises on the edge the count reaches WDOG_CYCLES.
            if (wdog_q >= CNT_W'(WDOG_CYCLES - 1)) begin
                lock_timeout_q <= 1'b1;
            end
        end else begin
            wdog_q <= '0;
        end
    end

    assign lock_timeout = lock_timeout_q;
`else
    assign lock_timeout = 1'b0;
`endif

    assign domain_reset = dr_q;
    assign seq_done     = done_q;
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_reset_sequencer.sv
module tb_reset_sequencer;

    localparam int NUM_DOMAINS = 3;
    localparam int LOCK_FILTER = 4;
    localparam int HOLD_CYCLES = 8;
    localparam int STEP_CYCLES = 4;
    localparam int WDOG_CYCLES = 100;

`ifdef RST_SEQ_WATCHDOG_EN
    localparam logic WD = 1'b1;
`else
    localparam logic WD = 1'b0;
`endif

    localparam logic [1:0] S_WAIT = 2'd0;
    localparam logic [1:0] S_HOLD = 2'd1;
    localparam logic [1:0] S_REL  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic       clk = 1'b0;
    logic       async_reset;
    logic       pll_locked;
    logic       sw_reset_req;
    logic [2:0] domain_reset;
    logic       seq_done;
    logic       lock_timeout;
    logic [1:0] state_dbg;

    int n_cmp = 0;
    int n_err = 0;
    int edge_cnt = 0;
    int tag = 0;
    logic lt_exp = 1'b0;

    typedef struct {
        int         cyc;
        logic [6:0] want;
        int         tag;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_item;

    reset_sequencer #(
        .NUM_DOMAINS (NUM_DOMAINS),
        .LOCK_FILTER (LOCK_FILTER),
        .HOLD_CYCLES (HOLD_CYCLES),
        .STEP_CYCLES (STEP_CYCLES),
        .WDOG_CYCLES (WDOG_CYCLES)
    ) dut (
        .clk          (clk),
        .async_reset  (async_reset),
        .pll_locked   (pll_locked),
        .sw_reset_req (sw_reset_req),
        .domain_reset (domain_reset),
        .seq_done     (seq_done),
        .lock_timeout (lock_timeout),
        .state_dbg    (state_dbg)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input int t, input int cyc, input logic [6:0] got, input logic [6:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL chk%0d @edge %0d: got dr=%b done=%b st=%0d lt=%b, expected dr=%b done=%b st=%0d lt=%b",
                     t, cyc, got[6:4], got[3], got[2:1], got[0], want[6:4], want[3], want[2:1], want[0]);
        end
    endtask

    task automatic push(input int cyc, input logic [2:0] dr, input logic done,
                        input logic [1:0] st, input logic lt);
        exp_t it;
        tag++;
        it.cyc  = cyc;
        it.want = {dr, done, st, lt};
        it.tag  = tag;
        exp_q.push_back(it);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: on each falling edge, compare every expectation due at this edge.
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc <= edge_cnt) begin
            mon_item = exp_q.pop_front();
            if (mon_item.cyc < edge_cnt) begin
                n_cmp++;
                n_err++;
                $display("FAIL chk%0d: expectation for edge %0d not sampled (now edge %0d)",
                         mon_item.tag, mon_item.cyc, edge_cnt);
            end else begin
                check(mon_item.tag, edge_cnt,
                      {domain_reset, seq_done, state_dbg, lock_timeout}, mon_item.want);
            end
        end
    end

    initial begin
        int p, e0, s, s2, g, t, r;
        async_reset  = 1'b1;
        pll_locked   = 1'b0;
        sw_reset_req = 1'b0;

        // Reset state and watchdog window (pll held low).
        tick(2);
        push(edge_cnt, 3'b111, 1'b0, S_WAIT, 1'b0);
        async_reset = 1'b0;
        p = edge_cnt;
        push(p + 2,   3'b111, 1'b0, S_WAIT, 1'b0);
        push(p + 102, 3'b111, 1'b0, S_WAIT, 1'b0);
        push(p + 103, 3'b111, 1'b0, S_WAIT, WD);
        push(p + 110, 3'b111, 1'b0, S_WAIT, WD);
        lt_exp = WD;
        tick(110);

        // Nominal: lock rises before E0.
        pll_locked = 1'b1;
        e0 = edge_cnt + 1;
        push(e0 + 5,  3'b111, 1'b0, S_WAIT, lt_exp);
        push(e0 + 6,  3'b111, 1'b0, S_HOLD, lt_exp);
        push(e0 + 13, 3'b111, 1'b0, S_HOLD, lt_exp);
        push(e0 + 14, 3'b110, 1'b0, S_REL,  lt_exp);
        push(e0 + 17, 3'b110, 1'b0, S_REL,  lt_exp);
        push(e0 + 18, 3'b100, 1'b0, S_REL,  lt_exp);
        push(e0 + 21, 3'b100, 1'b0, S_REL,  lt_exp);
        push(e0 + 22, 3'b000, 1'b1, S_DONE, lt_exp);
        tick(26);

        // Software reset from DONE.
        s = edge_cnt;
        push(s + 1,  3'b111, 1'b0, S_HOLD, lt_exp);
        push(s + 8,  3'b111, 1'b0, S_HOLD, lt_exp);
        push(s + 9,  3'b110, 1'b0, S_REL,  lt_exp);
        push(s + 16, 3'b100, 1'b0, S_REL,  lt_exp);
        push(s + 17, 3'b000, 1'b1, S_DONE, lt_exp);
        sw_reset_req = 1'b1;
        tick(1);
        sw_reset_req = 1'b0;
        tick(19);

        // Lock loss while domain_reset = 110.
        s2 = edge_cnt;
        push(s2 + 9, 3'b110, 1'b0, S_REL, lt_exp);
        sw_reset_req = 1'b1;
        tick(1);
        sw_reset_req = 1'b0;
        tick(8);
        pll_locked = 1'b0;
        push(s2 + 11, 3'b110, 1'b0, S_REL,  lt_exp);
        push(s2 + 12, 3'b111, 1'b0, S_WAIT, lt_exp);
        push(s2 + 16, 3'b111, 1'b0, S_WAIT, lt_exp);
        tick(11);

        // Lock glitch: high 3 cycles, low 1, then high.
        g = edge_cnt;
        push(g + 7,  3'b111, 1'b0, S_WAIT, lt_exp);
        push(g + 10, 3'b111, 1'b0, S_WAIT, lt_exp);
        push(g + 11, 3'b111, 1'b0, S_HOLD, lt_exp);
        push(g + 18, 3'b111, 1'b0, S_HOLD, lt_exp);
        push(g + 19, 3'b110, 1'b0, S_REL,  lt_exp);
        push(g + 23, 3'b100, 1'b0, S_REL,  lt_exp);
        pll_locked = 1'b1;
        tick(3);
        pll_locked = 1'b0;
        tick(1);
        pll_locked = 1'b1;
        tick(20);

        // Async reset in HOLD: outputs must change with no clock edge.
        t = edge_cnt;
        push(t + 1, 3'b111, 1'b0, S_HOLD, lt_exp);
        sw_reset_req = 1'b1;
        tick(1);
        sw_reset_req = 1'b0;
        tick(3);
        async_reset = 1'b1;
        lt_exp = 1'b0;
        #1;
        check(900, edge_cnt, {domain_reset, seq_done, state_dbg, lock_timeout},
              {3'b111, 1'b0, S_WAIT, 1'b0});
        push(t + 4, 3'b111, 1'b0, S_WAIT, 1'b0);
        tick(2);
        async_reset = 1'b0;
        r = edge_cnt;
        push(r + 3,  3'b111, 1'b0, S_WAIT, 1'b0);
        push(r + 9,  3'b111, 1'b0, S_WAIT, 1'b0);
        push(r + 10, 3'b111, 1'b0, S_HOLD, 1'b0);
        push(r + 18, 3'b110, 1'b0, S_REL,  1'b0);
        push(r + 26, 3'b000, 1'b1, S_DONE, 1'b0);
        tick(30);

        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Board-level reset controller that turns one asynchronous active-high reset and an asynchronous PLL/MMCM lock indication into `NUM_DOMAINS` staged, active-high, clk-synchronous domain resets. It synchronizes its own reset, filters the lock signal, holds all domains in reset for a minimum time, and then releases them one at a time in index order. It sits at the top of the clocking/reset tree, and each domain reset output feeds the per-domain reset synchronizers.

## Interface
- `NUM_DOMAINS`, 4: number of staged reset outputs (1..16).
- `LOCK_FILTER`, 8: consecutive synced-lock-high cycles required before lock is accepted (≥1).
- `HOLD_CYCLES`, 64: cycles all domains stay in reset after lock is accepted (≥1).
- `STEP_CYCLES`, 16: cycles between consecutive domain releases (≥1).
- `WDOG_CYCLES`, 65536: lock watchdog limit. Used only with `RST_SEQ_WATCHDOG_EN`.
- `clk` in 1: sequencer clock, free-running and independent of the PLL.
- `async_reset` in 1: asynchronous, active-high reset.
- `pll_locked` in 1: asynchronous lock input, active high.
- `sw_reset_req` in 1: clk-synchronous single-cycle request to re-run the sequence.
- `domain_reset` out `NUM_DOMAINS`: active-high reset per domain. Bit 0 is released first.
- `seq_done` out 1: high when all domains are released.
- `lock_timeout` out 1: sticky watchdog flag.
- `state_dbg` out 2: current FSM state encoding.

## Operation
- Internal reset `rst_i` is produced from `async_reset` with a 3-stage async-assert/sync-deassert synchronizer.
  - `rst_i` asserts asynchronously.
  - `rst_i` deasserts on the 3rd clk edge after `async_reset` falls.
- While `rst_i` is high, outputs are forced as follows:
  - `domain_reset` = all ones, applied asynchronously.
  - `seq_done` = 0, `lock_timeout` = 0.
  - State = WAIT_LOCK, and all counters = 0.
- `pll_locked` passes through a 2-flop synchronizer (ASYNC_REG) to give `lock_s`.
- FSM states (encoding in package):
  - WAIT_LOCK (0): filter counter increments while `lock_s` = 1 and clears to 0 when `lock_s` = 0. When the counter reaches `LOCK_FILTER`, go to HOLD with counter cleared.
  - HOLD (1): counter counts `HOLD_CYCLES`, then go to RELEASE with index = 0.
  - RELEASE (2):
    - On entry, clear `domain_reset[idx]`.
    - Each subsequent `STEP_CYCLES` cycles, increment `idx` and clear the next bit.
    - When bit `NUM_DOMAINS-1` clears, go to DONE.
  - DONE (3): `seq_done` = 1. Stay here.
- Released bits stay low. Bits are never re-asserted individually.
- Lock loss: `lock_s` = 0 in HOLD, RELEASE or DONE causes the following on the next edge:
  - `domain_reset` = all ones.
  - `seq_done` = 0.
  - State → WAIT_LOCK, counters cleared.
- `sw_reset_req` in RELEASE or DONE causes the following on the next edge:
  - `domain_reset` = all ones.
  - `seq_done` = 0.
  - State → HOLD, counter cleared. Lock filtering is skipped.
- `sw_reset_req` in WAIT_LOCK or HOLD is ignored.
- If lock loss and `sw_reset_req` occur in the same cycle, lock loss wins.
- Counter width is `$clog2(max(LOCK_FILTER,HOLD_CYCLES,STEP_CYCLES,WDOG_CYCLES)+1)`. Counters saturate and never wrap.

## Timing
- All outputs are registered. No combinational path from any input to any output.
- `domain_reset` assertion is asynchronous on `async_reset`. All deassertions are synchronous to clk.
- Let `pll_locked` rise (setup met) before edge E0, with FSM in WAIT_LOCK.
  - `domain_reset[0]` falls after edge E0 + 2 + `LOCK_FILTER` + `HOLD_CYCLES`.
  - `domain_reset[k]` falls exactly k·`STEP_CYCLES` edges after `domain_reset[0]`.
  - `seq_done` rises on the same edge as `domain_reset[NUM_DOMAINS-1]` falls.
- From `sw_reset_req` sampled at edge S:
  - All resets are asserted after edge S+1.
  - `domain_reset[0]` falls after edge S+1+`HOLD_CYCLES`.
- Lock-loss reaction latency is 3 edges from `pll_locked` falling: 2 synchronizer edges + 1 FSM edge.
- A lock glitch shorter than `LOCK_FILTER` cycles in WAIT_LOCK restarts filtering and does not advance state.

## Configuration
- `RST_SEQ_WATCHDOG_EN` defined:
  - A watchdog counter runs in WAIT_LOCK and clears on leaving WAIT_LOCK.
  - When it reaches `WDOG_CYCLES`, `lock_timeout` sets to 1 and stays set until `rst_i`.
  - The FSM is unaffected by the watchdog.
- `RST_SEQ_WATCHDOG_EN` not defined:
  - No watchdog logic is built.
  - `lock_timeout` is tied to 0.

## Structure
- Package `reset_sequencer_pkg` holds:
  - state typedef `rst_seq_state_t`: WAIT_LOCK=2'd0, HOLD=2'd1, RELEASE=2'd2, DONE=2'd3;
  - synchronizer depth localparams: 3 for reset, 2 for lock.
- One sub-module: `reset_sequencer_timer`. It is a loadable saturating down-counter with a `done` flag, shared for filter, hold and step timing.
- Internal reset synchronization reuses the team's existing async-assert/sync-deassert reset synchronizer.

## Test plan
Bench parameters unless stated otherwise: `NUM_DOMAINS`=3, `LOCK_FILTER`=4, `HOLD_CYCLES`=8, `STEP_CYCLES`=4.
- **Nominal:** `async_reset` pulse, then `pll_locked` high before E0.
  - `domain_reset` = 3'b111 until E14, then 3'b110.
  - 3'b100 at E18, 3'b000 and `seq_done` = 1 at E22.
- **Lock glitch:** `pll_locked` high for 3 cycles, low for 1, then high.
  - Remains in WAIT_LOCK.
  - Release times shift by the glitch. `domain_reset` stays 3'b111 throughout filtering.
- **Lock loss mid-RELEASE:** `pll_locked` drops when `domain_reset` = 3'b110.
  - 3 edges later: `domain_reset` = 3'b111, `state_dbg` = 0, `seq_done` = 0.
- **Software reset in DONE:** `sw_reset_req` pulse at S.
  - `domain_reset` = 3'b111 at S+1.
  - `domain_reset[0]` low at S+9.
  - `seq_done` at S+17.
- **Async reset mid-HOLD:** assert `async_reset` during HOLD.
  - Outputs reset immediately, without a clk edge.
  - After release, the sequence restarts from WAIT_LOCK.
- **Watchdog (`RST_SEQ_WATCHDOG_EN` defined, `WDOG_CYCLES`=100):** `pll_locked` held low.
  - `lock_timeout` = 1 at cycle 100 and stays set after lock arrives.
  - Without the macro, `lock_timeout` stays 0.
